alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Sequencer and arbiter that time-shares one combinational `alu` instance (DATA_WIDTH operands, 4-bit Operation) between two requesters, such as the integer pipeline and a multi-cycle helper unit. It accepts one operation at a time over valid/ready request channels and grants round-robin. It drives the ALU from registered operands, captures ALUResult into a result register, and returns it on a single response channel tagged with the requester ID.

## Interface
- DATA_WIDTH, 32, operand/result width; must match the shared alu
- OPCODE_LENGTH, 4, ALU operation code width
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present on port 0 / 1
- req0_ready / req1_ready  out  1  port accepted this cycle when valid&ready
- req0_a, req0_b / req1_a, req1_b  in  DATA_WIDTH  operands
- req0_op / req1_op  in  OPCODE_LENGTH  ALU operation code
- alu_srca, alu_srcb  out  DATA_WIDTH  to ALU SrcA/SrcB
- alu_op  out  OPCODE_LENGTH  to ALU Operation
- alu_result  in  DATA_WIDTH  from ALU ALUResult
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  requester that owns the result (0/1)
- resp_result  out  DATA_WIDTH  captured ALU result
- resp_err  out  1  illegal opcode flag (see Configuration)
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- In IDLE, the grant is computed combinationally:
  - Only one valid: grant that port.
  - Both valid: grant the port not granted last (`last_id` register).
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high; ready never asserts outside IDLE.
- IDLE → EXEC on a handshake: latch a, b, op, id into the operand registers and set last_id to the granted port.
- EXEC: alu_srca/alu_srcb/alu_op are driven from the operand registers. At the end of the cycle, alu_result goes into the result register and resp_id ← the latched id. Go to RESP.
- RESP: resp_valid=1. resp_result, resp_id and resp_err hold stable until resp_ready=1, then return to IDLE.
- Outside EXEC, alu_srca/alu_srcb/alu_op still reflect the operand registers. Consumers must ignore alu_result outside EXEC.
- A request not granted stays pending. Requesters must hold valid and payload stable until ready (AXI-style). The arbiter does not check this.
- All widths follow the parameters. No arithmetic is performed in this block.

## Timing
- Reset (async assert, sync deassert handled externally):
  - state=IDLE, last_id=1 (so port 0 wins the first tie).
  - Operand, op and result registers = 0; resp_valid=0, resp_id=0, resp_err=0, busy=0.
- Latency: handshake at cycle T → EXEC at T+1 → resp_valid high at T+2.
- Minimum occupancy is 3 cycles per operation (resp_ready held 1). Peak throughput is 1 op / 3 cycles.
- resp_ready low in RESP: stall indefinitely, with all outputs held and both readys low.
- The new grant in IDLE at T+3 uses last_id, so with both ports continuously valid the grants alternate 0,1,0,1.
- Reset mid-EXEC or mid-RESP: the operation is dropped with no response, and all outputs return to their reset values immediately (asynchronous).
- resp_ready asserted outside RESP has no effect.

## Configuration
- ALU_ARB_OPCHK_EN defined:
  - At the handshake, op is checked against the supported set {0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 1000 EQ}.
  - An unsupported op sets the latched err bit. resp_err=1 in RESP and resp_result is forced to 0.
  - The response is otherwise unchanged: same latency, same id.
- ALU_ARB_OPCHK_EN undefined:
  - No check; resp_err is tied to 0.
  - Unsupported ops pass to the ALU, which returns 0.

## Test plan
- Reset, then port 0 only: a=5, b=3, op=0010 at T → resp_valid at T+2, resp_result=8, resp_id=0, resp_err=0.
- Both valid in the same cycle after reset: port 0 a=7 b=2 op=0011, port 1 a=0xF0 b=0x0F op=0001.
  - Required: port 0 granted first → result 5, id 0.
  - Then port 1 → 0xFF, id 1.
  - Second handshake 3 cycles after the first.
- Backpressure: hold resp_ready=0 for 4 cycles in RESP with port 1 valid.
  - Required: resp_result/resp_id stable, req1_ready=0 throughout.
  - Port 1 is accepted the cycle after resp_ready=1.
- Port 1 issues op=0101, a=1, b=1:
  - With ALU_ARB_OPCHK_EN: resp_err=1, resp_result=0.
  - Without it: resp_err=0, resp_result=0.
- Assert reset_n=0 during EXEC of op 0010 a=1 b=1 → resp_valid=0 and busy=0 immediately, no response after release. The next request for port 0 (a=4, b=4, op=1000) returns 1.
- Both ports valid continuously for 6 operations → grant order 0,1,0,1,0,1, and no response is lost or duplicated.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sequencer sharing one combinational ALU between two requesters
//
// Time-shares a single external ALU between request ports 0 and 1. One operation
// is in flight at a time: IDLE (grant + handshake) -> EXEC (ALU driven from the
// operand registers, result captured) -> RESP (held until the consumer accepts).
//
// Optional feature macro: ALU_ARB_OPCHK_EN
//   defined   - opcode checked at handshake; an unsupported opcode returns
//               o_resp_err=1 with o_resp_result forced to 0
//   undefined - no check, o_resp_err is always 0
//
// Ports:
//   i_clk, i_reset_n                 clock (rising edge), async active-low reset
//   i_reqN_valid / o_reqN_ready      request handshake, port N = 0/1
//   i_reqN_a, i_reqN_b, i_reqN_op    request operands and ALU operation
//   o_alu_srca, o_alu_srcb, o_alu_op to the shared ALU (from operand registers)
//   i_alu_result                     from the shared ALU
//   o_resp_valid / i_resp_ready      response handshake
//   o_resp_id, o_resp_result         owning requester and captured result
//   o_resp_err                       unsupported-opcode flag
//   o_busy                           an operation is in flight
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_req0_valid,
    output logic                     o_req0_ready,
    input  logic [DATA_WIDTH-1:0]    i_req0_a,
    input  logic [DATA_WIDTH-1:0]    i_req0_b,
    input  logic [OPCODE_LENGTH-1:0] i_req0_op,
    input  logic                     i_req1_valid,
    output logic                     o_req1_ready,
    input  logic [DATA_WIDTH-1:0]    i_req1_a,
    input  logic [DATA_WIDTH-1:0]    i_req1_b,
    input  logic [OPCODE_LENGTH-1:0] i_req1_op,
    output logic [DATA_WIDTH-1:0]    o_alu_srca,
    output logic [DATA_WIDTH-1:0]    o_alu_srcb,
    output logic [OPCODE_LENGTH-1:0] o_alu_op,
    input  logic [DATA_WIDTH-1:0]    i_alu_result,
    output logic                     o_resp_valid,
    input  logic                     i_resp_ready,
    output logic                     o_resp_id,
    output logic [DATA_WIDTH-1:0]    o_resp_result,
    output logic                     o_resp_err,
    output logic                     o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;

    logic                     r_last_id;
    logic [DATA_WIDTH-1:0]    r_a;
    logic [DATA_WIDTH-1:0]    r_b;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic                     r_id;
    logic                     r_err;
    logic [DATA_WIDTH-1:0]    r_result;
    logic                     r_resp_id;
    logic                     r_resp_err;

    logic                     w_any_valid;
    logic                     w_grant;
    logic                     w_handshake;
    logic [DATA_WIDTH-1:0]    w_sel_a;
    logic [DATA_WIDTH-1:0]    w_sel_b;
    logic [OPCODE_LENGTH-1:0] w_sel_op;
    logic                     w_op_bad;

    // Grant: a lone requester wins; on a tie the port not served last wins.
    assign w_any_valid = i_req0_valid | i_req1_valid;
    assign w_grant     = (i_req0_valid & i_req1_valid) ? ~r_last_id : i_req1_valid;
    assign w_handshake = (r_state == S_IDLE) & w_any_valid;

    assign w_sel_a  = w_grant ? i_req1_a  : i_req0_a;
    assign w_sel_b  = w_grant ? i_req1_b  : i_req0_b;
    assign w_sel_op = w_grant ? i_req1_op : i_req0_op;

`ifdef ALU_ARB_OPCHK_EN
    // Supported set: AND, OR, ADD, SUB, XOR, EQ.
    always_comb begin
        w_op_bad = 1'b1;
        if ((w_sel_op == OPCODE_LENGTH'(4'b0000)) ||
            (w_sel_op == OPCODE_LENGTH'(4'b0001)) ||
            (w_sel_op == OPCODE_LENGTH'(4'b0010)) ||
            (w_sel_op == OPCODE_LENGTH'(4'b0011)) ||
            (w_sel_op == OPCODE_LENGTH'(4'b0100)) ||
            (w_sel_op == OPCODE_LENGTH'(4'b1000))) begin
            w_op_bad = 1'b0;
        end
    end
`else
    assign w_op_bad = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_valid) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (i_resp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_resp_valid = 1'b0;
        o_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                o_busy       = 1'b0;
                o_req0_ready = w_any_valid & ~w_grant;
                o_req1_ready = w_any_valid &  w_grant;
            end
            S_RESP:  o_resp_valid = 1'b1;
            default: o_busy = 1'b1;
        endcase
    end

    // Operand capture at handshake, result capture at the end of EXEC.
    // last_id resets to 1 so port 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_last_id  <= 1'b1;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_id       <= 1'b0;
            r_err      <= 1'b0;
            r_result   <= '0;
            r_resp_id  <= 1'b0;
            r_resp_err <= 1'b0;
        end else begin
            if (w_handshake) begin
                r_a       <= w_sel_a;
                r_b       <= w_sel_b;
                r_op      <= w_sel_op;
                r_id      <= w_grant;
                r_err     <= w_op_bad;
                r_last_id <= w_grant;
            end
            if (r_state == S_EXEC) begin
                r_result   <= r_err ? '0 : i_alu_result;
                r_resp_id  <= r_id;
                r_resp_err <= r_err;
            end
        end
    end

    assign o_alu_srca    = r_a;
    assign o_alu_srcb    = r_b;
    assign o_alu_op      = r_op;
    assign o_resp_result = r_result;
    assign o_resp_id     = r_resp_id;
    assign o_resp_err    = r_resp_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

`ifdef ALU_ARB_OPCHK_EN
    localparam bit OPCHK = 1'b1;
`else
    localparam bit OPCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tb_v [2];
    logic [31:0] tb_a [2];
    logic [31:0] tb_b [2];
    logic [3:0]  tb_op[2];
    logic        rdy0, rdy1;
    logic [31:0] alu_srca, alu_srcb, alu_result;
    logic [3:0]  alu_op;
    logic        resp_valid, resp_ready, resp_id, resp_err, busy;
    logic [31:0] resp_result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a - b;
            4'b0100: return a ^ b;
            4'b1000: return (a == b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic op_bad(logic [3:0] op);
        return OPCHK && !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1000});
    endfunction

    // Stand-in for the shared combinational ALU
    always_comb alu_result = alu_ref(alu_srca, alu_srcb, alu_op);

    alu_share_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_req0_valid(tb_v[0]), .o_req0_ready(rdy0),
        .i_req0_a(tb_a[0]), .i_req0_b(tb_b[0]), .i_req0_op(tb_op[0]),
        .i_req1_valid(tb_v[1]), .o_req1_ready(rdy1),
        .i_req1_a(tb_a[1]), .i_req1_b(tb_b[1]), .i_req1_op(tb_op[1]),
        .o_alu_srca(alu_srca), .o_alu_srcb(alu_srcb), .o_alu_op(alu_op),
        .i_alu_result(alu_result),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_id(resp_id), .o_resp_result(resp_result), .o_resp_err(resp_err),
        .o_busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tb_v[0] = 1'b0;
        tb_v[1] = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        tb_a[p]  = a;
        tb_b[p]  = b;
        tb_op[p] = op;
        tb_v[p]  = 1'b1;
    endtask

    // Single-port operation with latency and response checks; called at posedge+1.
    task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input string nm, input logic [31:0] exp_res, input logic exp_err);
        bit got = 0;
        resp_ready = 1'b1;
        set_req(p, a, b, op);
        for (int t = 0; t < 10 && !got; t++) begin
            @(negedge clk);
            if ((p == 1) ? rdy1 : rdy0) got = 1;
            else tick();
        end
        if (!got) begin
            chk({nm, "_handshake_timeout"}, 32'd0, 32'd1);
            tb_v[p] = 1'b0;
            return;
        end
        tick();
        tb_v[p] = 1'b0;
        @(negedge clk);
        chk({nm, "_exec_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({nm, "_exec_busy"}, {31'd0, busy}, 32'd1);
        tick();
        @(negedge clk);
        chk({nm, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({nm, "_resp_result"}, resp_result, exp_res);
        chk({nm, "_resp_id"}, {31'd0, resp_id}, p);
        chk({nm, "_resp_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        tick();
    endtask

    typedef struct {
        int          port;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        id;
        logic        err;
    } exp_t;

    vec_t tbl[9];

    initial begin
        exp_t q[$];
        exp_t e;
        int   ngrant, nresp, acc, g;
        int   m_st, m_last, m_nresp, m_nhs;
        logic [31:0] m_res;
        logic m_id, m_err;
        logic acc_r[2];

        tbl[0] = '{0, 32'd5,        32'd3,    4'b0010, 32'd8,    1'b0};
        tbl[1] = '{1, 32'hF0,       32'h0F,   4'b0001, 32'hFF,   1'b0};
        tbl[2] = '{0, 32'd7,        32'd2,    4'b0011, 32'd5,    1'b0};
        tbl[3] = '{1, 32'd1,        32'd1,    4'b0101, 32'd0,    OPCHK};
        tbl[4] = '{0, 32'd4,        32'd4,    4'b1000, 32'd1,    1'b0};
        tbl[5] = '{1, 32'hFFFFFFFF, 32'd1,    4'b0010, 32'd0,    1'b0};
        tbl[6] = '{0, 32'hA5,       32'h0F,   4'b0000, 32'h05,   1'b0};
        tbl[7] = '{1, 32'hFF,       32'h0F,   4'b0100, 32'hF0,   1'b0};
        tbl[8] = '{0, 32'd3,        32'd4,    4'b1000, 32'd0,    1'b0};

        for (int p = 0; p < 2; p++) begin
            tb_v[p] = 1'b0; tb_a[p] = '0; tb_b[p] = '0; tb_op[p] = '0;
        end
        resp_ready = 1'b0;

        // Reset state
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_alu_srca", alu_srca, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_ready0", {31'd0, rdy0}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Table of single-port operations
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].op, $sformatf("vec%0d", i),
                  tbl[i].exp_res, tbl[i].exp_err);
        end

        // Tie after reset: port 0 first, port 1 three cycles later
        do_reset();
        resp_ready = 1'b1;
        set_req(0, 32'd7, 32'd2, 4'b0011);
        set_req(1, 32'hF0, 32'h0F, 4'b0001);
        @(negedge clk);
        chk("tie_ready0", {31'd0, rdy0}, 32'd1);
        chk("tie_ready1", {31'd0, rdy1}, 32'd0);
        tick(); tb_v[0] = 1'b0;
        @(negedge clk);
        chk("tie_exec_ready1", {31'd0, rdy1}, 32'd0);
        tick();
        @(negedge clk);
        chk("tie_r0_result", resp_result, 32'd5);
        chk("tie_r0_id", {31'd0, resp_id}, 32'd0);
        chk("tie_resp_ready1", {31'd0, rdy1}, 32'd0);
        tick();
        @(negedge clk);
        chk("tie_t3_ready1", {31'd0, rdy1}, 32'd1);
        tick(); tb_v[1] = 1'b0;
        tick();
        @(negedge clk);
        chk("tie_r1_valid", {31'd0, resp_valid}, 32'd1);
        chk("tie_r1_result", resp_result, 32'hFF);
        chk("tie_r1_id", {31'd0, resp_id}, 32'd1);
        tick();

        // Backpressure with port 1 waiting
        resp_ready = 1'b0;
        set_req(0, 32'd9, 32'd4, 4'b0011);
        @(negedge clk);
        chk("bp_ready0", {31'd0, rdy0}, 32'd1);
        tick(); tb_v[0] = 1'b0;
        set_req(1, 32'd2, 32'd3, 4'b0010);
        @(negedge clk);
        chk("bp_exec_ready1", {31'd0, rdy1}, 32'd0);
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_hold_result", resp_result, 32'd5);
            chk("bp_hold_id", {31'd0, resp_id}, 32'd0);
            chk("bp_hold_ready1", {31'd0, rdy1}, 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready1", {31'd0, rdy1}, 32'd0);
        tick();
        @(negedge clk);
        chk("bp_accept_ready1", {31'd0, rdy1}, 32'd1);
        tick(); tb_v[1] = 1'b0;
        tick();
        @(negedge clk);
        chk("bp_r1_result", resp_result, 32'd5);
        chk("bp_r1_id", {31'd0, resp_id}, 32'd1);
        tick();

        // Reset during EXEC drops the operation
        set_req(0, 32'd1, 32'd1, 4'b0010);
        @(negedge clk);
        chk("rx_ready0", {31'd0, rdy0}, 32'd1);
        tick(); tb_v[0] = 1'b0;
        #2;
        chk("rx_exec_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rx_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rx_busy", {31'd0, busy}, 32'd0);
        chk("rx_resp_result", resp_result, 32'd0);
        chk("rx_resp_id", {31'd0, resp_id}, 32'd0);
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rx_no_resp", {31'd0, resp_valid}, 32'd0);
            tick();
        end
        do_op(0, 32'd4, 32'd4, 4'b1000, "rx_next", 32'd1, 1'b0);

        // Both ports continuously valid: grants alternate 0,1,0,...
        do_reset();
        resp_ready = 1'b1;
        set_req(0, $urandom, $urandom, 4'b0010);
        set_req(1, $urandom, $urandom, 4'b0100);
        ngrant = 0; nresp = 0; acc = -1;
        for (int c = 0; c < 60 && nresp < 6; c++) begin
            @(negedge clk);
            if (rdy0 || rdy1) begin
                g = rdy1 ? 1 : 0;
                chk($sformatf("rr_grant%0d", ngrant), g, ngrant % 2);
                e.res = alu_ref(tb_a[ngrant % 2], tb_b[ngrant % 2], tb_op[ngrant % 2]);
                e.id  = 1'((ngrant % 2));
                e.err = 1'b0;
                q.push_back(e);
                ngrant++;
                acc = g;
            end
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("rr_spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("rr_result%0d", nresp), resp_result, e.res);
                    chk($sformatf("rr_id%0d", nresp), {31'd0, resp_id}, {31'd0, e.id});
                end
                nresp++;
            end
            tick();
            if (acc >= 0) begin
                tb_a[acc] = $urandom;
                tb_b[acc] = $urandom;
                if (ngrant >= 6) tb_v[acc] = 1'b0;
                acc = -1;
            end
        end
        chk("rr_grant_count", ngrant, 32'd6);
        chk("rr_resp_count", nresp, 32'd6);
        tb_v[0] = 1'b0;
        tb_v[1] = 1'b0;

        // Randomized traffic against a transaction-level model
        do_reset();
        m_st = 0; m_last = 1; m_nresp = 0; m_nhs = 0;
        m_res = '0; m_id = 1'b0; m_err = 1'b0;
        acc_r[0] = 1'b0; acc_r[1] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (acc_r[p]) begin tb_v[p] = 1'b0; acc_r[p] = 1'b0; end
                if (!tb_v[p] && $urandom_range(0, 2) == 0) begin
                    set_req(p, $urandom_range(0, 3) == 0 ? 32'd7 : $urandom,
                            $urandom_range(0, 3) == 0 ? 32'd7 : $urandom,
                            4'($urandom_range(0, 15)));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = (tb_v[0] && tb_v[1]) ? 1 - m_last : (tb_v[1] ? 1 : 0);
            chk("rnd_ready0", {31'd0, rdy0}, {31'd0, (m_st == 0) && tb_v[0] && g == 0});
            chk("rnd_ready1", {31'd0, rdy1}, {31'd0, (m_st == 0) && tb_v[1] && g == 1});
            chk("rnd_resp_valid", {31'd0, resp_valid}, {31'd0, m_st == 2});
            chk("rnd_busy", {31'd0, busy}, {31'd0, m_st != 0});
            if (m_st == 2) begin
                chk("rnd_result", resp_result, m_res);
                chk("rnd_id", {31'd0, resp_id}, {31'd0, m_id});
                chk("rnd_err", {31'd0, resp_err}, {31'd0, m_err});
            end
            case (m_st)
                0: if (tb_v[0] || tb_v[1]) begin
                    m_err  = op_bad(tb_op[g]);
                    m_res  = m_err ? 32'd0 : alu_ref(tb_a[g], tb_b[g], tb_op[g]);
                    m_id   = 1'(g);
                    m_last = g;
                    acc_r[g] = 1'b1;
                    m_nhs++;
                    m_st = 1;
                end
                1: m_st = 2;
                default: if (resp_ready) begin m_st = 0; m_nresp++; end
            endcase
            tick();
        end
        n_checks++;
        if (m_nhs < 20) begin
            n_errors++;
            $display("FAIL rnd_activity: handshakes=%0d required>=20", m_nhs);
        end
        tb_v[0] = 1'b0;
        tb_v[1] = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
